// File: rtl/bnn_conv_acc_pipe_pkg.sv
// ---------------------------------------------------------------------------
// bnn_conv_acc_pipe_pkg
//   Shared helpers for the binary-weight convolution accumulator:
//   - clog2 / sum_width : window-sum width derivation
//   - sat_add           : signed saturating add, clipped to a runtime width
//   - beat_ctrl_t       : per-stage valid/last control bits
//   - BNN_CONV_TAP      : slice tap j of width w out of a flat tap vector
// ---------------------------------------------------------------------------
`ifndef BNN_CONV_TAP
`define BNN_CONV_TAP(vec, j, w) vec[(j)*(w) +: (w)]
`endif

package bnn_conv_acc_pipe_pkg;

   // Working width of sat_add; any accumulator up to this width is supported.
   localparam int SAT_MAX_W = 64;

   typedef struct packed {
      logic valid;
      logic last;
   } beat_ctrl_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   // Sum of K*K taps, each widened by one bit so that -2^(DW-1) can be negated.
   function automatic int sum_width(input int dw, input int k);
      return dw + 1 + clog2(k * k);
   endfunction

   // a + b computed one bit wider, then clipped to the signed acc_w range.
   function automatic logic signed [SAT_MAX_W-1:0] sat_add(
      input  logic signed [SAT_MAX_W-1:0] a,
      input  logic signed [SAT_MAX_W-1:0] b,
      input  int                          acc_w,
      output logic                        sat
   );
      logic signed [SAT_MAX_W:0] s;
      logic signed [SAT_MAX_W:0] one;
      logic signed [SAT_MAX_W:0] hi;
      logic signed [SAT_MAX_W:0] lo;
      logic signed [SAT_MAX_W-1:0] r;
      one    = '0;
      one[0] = 1'b1;
      s      = {a[SAT_MAX_W-1], a} + {b[SAT_MAX_W-1], b};
      hi     = (one <<< (acc_w - 1)) - one;
      lo     = -(one <<< (acc_w - 1));
      sat    = 1'b0;
      if (s > hi) begin
         sat = 1'b1;
         r   = hi[SAT_MAX_W-1:0];
      end else if (s < lo) begin
         sat = 1'b1;
         r   = lo[SAT_MAX_W-1:0];
      end else begin
         r   = s[SAT_MAX_W-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/bnn_conv_acc_pipe_if.sv
// ---------------------------------------------------------------------------
// bnn_conv_acc_pipe_if
//   Beat input and result output of the convolution accumulator.
//   master : window source / result sink (drives in_*, out_ready, thresh)
//   slave  : the engine (drives in_ready, out_valid, dout, out_sat, out_bit)
//   Signals:
//     in_valid/in_ready/in_last  beat handshake, in_last closes a channel group
//     idata   K*K*DATA_WIDTH     tap j at [(j+1)*DW-1 : j*DW], row-major
//     weight  K*K                bit j: 1 => +x_j, 0 => -x_j
//     out_valid/out_ready        result handshake
//     dout    ACC_W signed       saturated group sum
//     out_sat                    saturation seen in the group
//   Optional (BNN_CONV_BINARIZE_EN): thresh in, out_bit = (dout >= thresh).
// ---------------------------------------------------------------------------
interface bnn_conv_acc_pipe_if #(
   parameter int DATA_WIDTH = 4,
   parameter int K          = 4,
   parameter int ACC_W      = 16
);
   logic                          in_valid;
   logic                          in_ready;
   logic                          in_last;
   logic [K*K*DATA_WIDTH-1:0]     idata;
   logic [K*K-1:0]                weight;
   logic                          out_valid;
   logic                          out_ready;
   logic signed [ACC_W-1:0]       dout;
   logic                          out_sat;
`ifdef BNN_CONV_BINARIZE_EN
   logic signed [ACC_W-1:0]       thresh;
   logic                          out_bit;

   modport master (
      output in_valid, in_last, idata, weight, out_ready, thresh,
      input  in_ready, out_valid, dout, out_sat, out_bit
   );
   modport slave (
      input  in_valid, in_last, idata, weight, out_ready, thresh,
      output in_ready, out_valid, dout, out_sat, out_bit
   );
`else
   modport master (
      output in_valid, in_last, idata, weight, out_ready,
      input  in_ready, out_valid, dout, out_sat
   );
   modport slave (
      input  in_valid, in_last, idata, weight, out_ready,
      output in_ready, out_valid, dout, out_sat
   );
`endif
endinterface

// File: rtl/bnn_conv_acc_pipe_adder_tree.sv
// ---------------------------------------------------------------------------
// bnn_conv_acc_pipe_adder_tree
//   Balanced combinational adder tree over N signed IN_W operands, result
//   sign-extended to OUT_W and registered when en=1.
//   Ports: clk, rst (async, active-high), en, in_vec_i (N*IN_W flat),
//          sum_o (OUT_W signed, registered).
// ---------------------------------------------------------------------------
module bnn_conv_acc_pipe_adder_tree
   import bnn_conv_acc_pipe_pkg::*;
#(
   parameter int N     = 16,
   parameter int IN_W  = 5,
   parameter int OUT_W = 9
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [N*IN_W-1:0]       in_vec_i,
   output logic signed [OUT_W-1:0] sum_o
);
   localparam int LEVELS = clog2(N);
   localparam int LEAVES = 1 << LEVELS;

   logic signed [OUT_W-1:0] leaf [LEAVES];
   logic signed [OUT_W-1:0] node [2*LEAVES-1];
   logic signed [OUT_W-1:0] sum_d;
   logic signed [OUT_W-1:0] sum_q;

   // Pad to a power of two with zeros so the tree is perfectly balanced.
   for (genvar gi = 0; gi < LEAVES; gi++) begin : g_leaf
      if (gi < N) begin : g_used
         assign leaf[gi] = OUT_W'(signed'(in_vec_i[gi*IN_W +: IN_W]));
      end else begin : g_pad
         assign leaf[gi] = '0;
      end
   end

   // Heap layout: leaves at LEAVES-1.., node n = child 2n+1 + child 2n+2.
   always_comb begin
      for (int n = 0; n < 2*LEAVES-1; n++) node[n] = '0;
      for (int i = 0; i < LEAVES; i++) node[LEAVES-1+i] = leaf[i];
      for (int n = LEAVES-2; n >= 0; n--) node[n] = node[2*n+1] + node[2*n+2];
      sum_d = node[0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q <= '0;
      end else if (en) begin
         sum_q <= sum_d;
      end
   end

   assign sum_o = sum_q;
endmodule

// File: rtl/bnn_conv_acc_pipe.sv
// ---------------------------------------------------------------------------
// bnn_conv_acc_pipe
//   Three-stage binary-weight KxK convolution with cross-channel accumulation.
//     S1: per-tap +/-x products (registered)
//     S2: adder tree window sum (registered, bnn_conv_acc_pipe_adder_tree)
//     S3: saturating accumulate; on the last beat the group result is issued
//   The whole pipe stalls while a result waits for out_ready.
//   Ports: clk, rst (async, active-high), bus (bnn_conv_acc_pipe_if.slave).
//   Macro BNN_CONV_BINARIZE_EN adds bus.thresh / bus.out_bit.
// ---------------------------------------------------------------------------
module bnn_conv_acc_pipe
   import bnn_conv_acc_pipe_pkg::*;
#(
   parameter int DATA_WIDTH = 4,
   parameter int K          = 4,
   parameter int ACC_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   bnn_conv_acc_pipe_if.slave    bus
);
   localparam int TAPS  = K * K;
   localparam int PW    = DATA_WIDTH + 1;
   localparam int SUM_W = sum_width(DATA_WIDTH, K);

   logic                     en;
   logic [TAPS*PW-1:0]       prod_d;
   logic [TAPS*PW-1:0]       prod_q;
   beat_ctrl_t               s1_ctrl_q;
   beat_ctrl_t               s2_ctrl_q;
   logic signed [SUM_W-1:0]  sum_q;
   logic signed [ACC_W-1:0]  acc_q;
   logic signed [ACC_W-1:0]  nxt_d;
   logic signed [ACC_W-1:0]  dout_q;
   logic                     step_sat;
   logic                     sat_q;
   logic                     out_sat_q;
   logic                     out_valid_q;

   // A result held back by the sink freezes every stage.
   assign en          = !(out_valid_q && !bus.out_ready);
   assign bus.in_ready = en;

   // S1: widen each tap by one bit before negating so -2^(DW-1) stays exact.
   for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
      logic signed [PW-1:0] tap_ext;
      assign tap_ext = PW'(signed'(`BNN_CONV_TAP(bus.idata, gi, DATA_WIDTH)));
      assign prod_d[gi*PW +: PW] = bus.weight[gi] ? tap_ext : -tap_ext;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prod_q    <= '0;
         s1_ctrl_q <= '0;
      end else if (en) begin
         prod_q          <= prod_d;
         s1_ctrl_q.valid <= bus.in_valid;
         s1_ctrl_q.last  <= bus.in_valid && bus.in_last;
      end
   end

   // S2
   bnn_conv_acc_pipe_adder_tree #(
      .N     (TAPS),
      .IN_W  (PW),
      .OUT_W (SUM_W)
   ) u_tree (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .in_vec_i (prod_q),
      .sum_o    (sum_q)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_ctrl_q <= '0;
      end else if (en) begin
         s2_ctrl_q <= s1_ctrl_q;
      end
   end

`ifdef BNN_CONV_BINARIZE_EN
   // Threshold rides alongside the beat; only the last beat's value matters.
   logic signed [ACC_W-1:0] s1_thresh_q;
   logic signed [ACC_W-1:0] s2_thresh_q;
   logic                    out_bit_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_thresh_q <= '0;
         s2_thresh_q <= '0;
      end else if (en) begin
         s1_thresh_q <= bus.thresh;
         s2_thresh_q <= s1_thresh_q;
      end
   end
`endif

   // S3 next accumulator value, saturated to ACC_W.
   always_comb begin
      step_sat = 1'b0;
      nxt_d    = ACC_W'(sat_add(SAT_MAX_W'(acc_q), SAT_MAX_W'(sum_q), ACC_W, step_sat));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q       <= '0;
         sat_q       <= 1'b0;
         dout_q      <= '0;
         out_sat_q   <= 1'b0;
         out_valid_q <= 1'b0;
`ifdef BNN_CONV_BINARIZE_EN
         out_bit_q   <= 1'b0;
`endif
      end else if (en) begin
         if (s2_ctrl_q.valid && s2_ctrl_q.last) begin
            // Issuing a new result also covers a same-edge consume of the old one.
            dout_q      <= nxt_d;
            out_sat_q   <= sat_q | step_sat;
            out_valid_q <= 1'b1;
            acc_q       <= '0;
            sat_q       <= 1'b0;
`ifdef BNN_CONV_BINARIZE_EN
            out_bit_q   <= (nxt_d >= s2_thresh_q);
`endif
         end else begin
            if (s2_ctrl_q.valid) begin
               acc_q <= nxt_d;
               sat_q <= sat_q | step_sat;
            end
            // en=1 here means any pending result is being consumed this edge.
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.dout      = dout_q;
   assign bus.out_sat   = out_sat_q;
`ifdef BNN_CONV_BINARIZE_EN
   assign bus.out_bit   = out_bit_q;
`endif
endmodule

// File: tb/tb_bnn_conv_acc_pipe.sv
`timescale 1ns/1ps
module tb_bnn_conv_acc_pipe;
   localparam int DW    = 4;
   localparam int K     = 4;
   localparam int ACC_A = 16;
   localparam int ACC_B = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bnn_conv_acc_pipe_if #(.DATA_WIDTH(DW), .K(K), .ACC_W(ACC_A)) bus_a ();
   bnn_conv_acc_pipe_if #(.DATA_WIDTH(DW), .K(K), .ACC_W(ACC_B)) bus_b ();

   // Second engine (narrow accumulator) sees identical stimulus.
   assign bus_b.in_valid  = bus_a.in_valid;
   assign bus_b.in_last   = bus_a.in_last;
   assign bus_b.idata     = bus_a.idata;
   assign bus_b.weight    = bus_a.weight;
   assign bus_b.out_ready = bus_a.out_ready;
`ifdef BNN_CONV_BINARIZE_EN
   assign bus_b.thresh    = bus_a.thresh[ACC_B-1:0];
`endif

   bnn_conv_acc_pipe #(.DATA_WIDTH(DW), .K(K), .ACC_W(ACC_A)) u_dut_a (
      .clk (clk), .rst (rst), .bus (bus_a));
   bnn_conv_acc_pipe #(.DATA_WIDTH(DW), .K(K), .ACC_W(ACC_B)) u_dut_b (
      .clk (clk), .rst (rst), .bus (bus_b));

   typedef struct {
      int dout;
      bit sat;
      bit obit;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   int   acc_a, acc_b;
   bit   sat_a, sat_b;
   int   n_vec = 0;
   int   n_err = 0;
   bit   rand_done;

   function automatic logic [63:0] fill(input logic [3:0] v);
      return {16{v}};
   endfunction

   function automatic int window_sum(input logic [63:0] d, input logic [15:0] w);
      int s = 0;
      for (int j = 0; j < 16; j++) begin
         logic signed [3:0] x;
         x = d[j*4 +: 4];
         s += w[j] ? int'(x) : -int'(x);
      end
      return s;
   endfunction

   function automatic int clip(input int v, input int width, output bit s);
      int hi, lo;
      hi = (1 << (width - 1)) - 1;
      lo = -(1 << (width - 1));
      s  = 1'b0;
      if (v > hi) begin s = 1'b1; return hi; end
      if (v < lo) begin s = 1'b1; return lo; end
      return v;
   endfunction

   task automatic model_beat(input logic [63:0] d, input logic [15:0] w, input bit last, input int th);
      int s, thb;
      bit st;
      logic signed [7:0] t8;
      exp_t e;
      s  = window_sum(d, w);
      t8 = th[7:0];
      thb = int'(t8);
      acc_a = clip(acc_a + s, ACC_A, st); sat_a |= st;
      acc_b = clip(acc_b + s, ACC_B, st); sat_b |= st;
      if (last) begin
         e.dout = acc_a; e.sat = sat_a; e.obit = (acc_a >= th);  q_a.push_back(e);
         e.dout = acc_b; e.sat = sat_b; e.obit = (acc_b >= thb); q_b.push_back(e);
         acc_a = 0; sat_a = 0; acc_b = 0; sat_b = 0;
      end
   endtask

   // Drive one beat; returns on the edge that accepted it.
   task automatic send_beat(input logic [63:0] d, input logic [15:0] w, input bit last, input int th);
      bit rdy, done;
      done = 1'b0;
      #1;
      bus_a.in_valid = 1'b1;
      bus_a.idata    = d;
      bus_a.weight   = w;
      bus_a.in_last  = last;
`ifdef BNN_CONV_BINARIZE_EN
      bus_a.thresh   = th[ACC_A-1:0];
`endif
      for (int i = 0; i < 64 && !done; i++) begin
         @(negedge clk);
         rdy = bus_a.in_ready;
         @(posedge clk);
         if (rdy && !rst) done = 1'b1;
      end
      n_vec++;
      if (!done) begin
         n_err++;
         $display("FAIL accept_timeout: in_ready=%0b required 1 within 64 clks", bus_a.in_ready);
      end else begin
         model_beat(d, w, last, th);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         #1;
         bus_a.in_valid = 1'b0;
         bus_a.in_last  = 1'b0;
         @(posedge clk);
      end
   endtask

   task automatic set_ready(input bit r);
      #1 bus_a.out_ready = r;
      @(posedge clk);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 200 && (q_a.size() != 0 || q_b.size() != 0); i++) @(posedge clk);
      n_vec++;
      if (q_a.size() != 0 || q_b.size() != 0) begin
         n_err++;
         $display("FAIL drain: pending a=%0d b=%0d required 0/0", q_a.size(), q_b.size());
      end
   endtask

   // Scoreboard: compare each consumed result against the oldest expectation.
   always @(negedge clk) begin : mon_a
      exp_t e;
      if (!rst && bus_a.out_valid && bus_a.out_ready) begin
         n_vec++;
         if (q_a.size() == 0) begin
            n_err++;
            $display("FAIL a_unexpected: dout=%0d required no result", bus_a.dout);
         end else begin
            e = q_a.pop_front();
            $display("result a: dout=%0d sat=%0b (expect %0d/%0b)", bus_a.dout, bus_a.out_sat, e.dout, e.sat);
            if (int'(bus_a.dout) !== e.dout) begin
               n_err++;
               $display("FAIL a_dout: got %0d required %0d", bus_a.dout, e.dout);
            end
            n_vec++;
            if (bus_a.out_sat !== e.sat) begin
               n_err++;
               $display("FAIL a_sat: got %0b required %0b", bus_a.out_sat, e.sat);
            end
`ifdef BNN_CONV_BINARIZE_EN
            n_vec++;
            if (bus_a.out_bit !== e.obit) begin
               n_err++;
               $display("FAIL a_out_bit: got %0b required %0b", bus_a.out_bit, e.obit);
            end
`endif
         end
      end
   end

   always @(negedge clk) begin : mon_b
      exp_t e;
      if (!rst && bus_b.out_valid && bus_b.out_ready) begin
         n_vec++;
         if (q_b.size() == 0) begin
            n_err++;
            $display("FAIL b_unexpected: dout=%0d required no result", bus_b.dout);
         end else begin
            e = q_b.pop_front();
            $display("result b: dout=%0d sat=%0b (expect %0d/%0b)", bus_b.dout, bus_b.out_sat, e.dout, e.sat);
            if (int'(bus_b.dout) !== e.dout) begin
               n_err++;
               $display("FAIL b_dout: got %0d required %0d", bus_b.dout, e.dout);
            end
            n_vec++;
            if (bus_b.out_sat !== e.sat) begin
               n_err++;
               $display("FAIL b_sat: got %0b required %0b", bus_b.out_sat, e.sat);
            end
`ifdef BNN_CONV_BINARIZE_EN
            n_vec++;
            if (bus_b.out_bit !== e.obit) begin
               n_err++;
               $display("FAIL b_out_bit: got %0b required %0b", bus_b.out_bit, e.obit);
            end
`endif
         end
      end
   end

   task automatic test_reset();
      bus_a.in_valid  = 1'b0;
      bus_a.in_last   = 1'b0;
      bus_a.idata     = '0;
      bus_a.weight    = '0;
      bus_a.out_ready = 1'b1;
`ifdef BNN_CONV_BINARIZE_EN
      bus_a.thresh    = '0;
`endif
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_vec++; if (bus_a.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid_a: got %0b required 0", bus_a.out_valid); end
      n_vec++; if (bus_a.dout !== 16'sd0) begin n_err++; $display("FAIL rst_dout_a: got %0d required 0", bus_a.dout); end
      n_vec++; if (bus_a.out_sat !== 1'b0) begin n_err++; $display("FAIL rst_sat_a: got %0b required 0", bus_a.out_sat); end
      n_vec++; if (bus_a.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_a: got %0b required 1", bus_a.in_ready); end
      n_vec++; if (bus_b.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid_b: got %0b required 0", bus_b.out_valid); end
      n_vec++; if (bus_b.dout !== 8'sd0) begin n_err++; $display("FAIL rst_dout_b: got %0d required 0", bus_b.dout); end
      rst = 1'b0;
      acc_a = 0; acc_b = 0; sat_a = 0; sat_b = 0;
      @(posedge clk);
   endtask

   // T1 plus latency: beat presented after edge t is registered at t+1,
   // and the result is visible after edge t+3.
   task automatic test_single();
      send_beat(fill(4'd1), 16'hFFFF, 1'b1, 16);
      #1 bus_a.in_valid = 1'b0;
      n_vec++; if (bus_a.out_valid !== 1'b0) begin n_err++; $display("FAIL lat_t1: out_valid=%0b required 0", bus_a.out_valid); end
      @(posedge clk); #1;
      n_vec++; if (bus_a.out_valid !== 1'b0) begin n_err++; $display("FAIL lat_t2: out_valid=%0b required 0", bus_a.out_valid); end
      @(posedge clk); #1;
      n_vec++; if (bus_a.out_valid !== 1'b1) begin n_err++; $display("FAIL lat_t3: out_valid=%0b required 1", bus_a.out_valid); end
      n_vec++; if (bus_a.dout !== 16'sd16) begin n_err++; $display("FAIL t1_dout: got %0d required 16", bus_a.dout); end
      @(posedge clk);
      wait_drain();
`ifdef BNN_CONV_BINARIZE_EN
      send_beat(fill(4'd1), 16'hFFFF, 1'b1, 17);
      idle(1);
      wait_drain();
`endif
   endtask

   task automatic test_negate();
      send_beat(fill(4'h8), 16'h0000, 1'b1, 0);
      idle(1);
      wait_drain();
   endtask

   task automatic test_back_to_back();
      send_beat(fill(4'd3), 16'hFFFF, 1'b0, 0);
      send_beat(fill(4'd3), 16'hFFFF, 1'b0, 0);
      send_beat(fill(4'd3), 16'hFFFF, 1'b1, 0);
      send_beat(fill(4'hF), 16'hFFFF, 1'b1, 0);
      #1 bus_a.in_valid = 1'b0;
      @(posedge clk); #1;
      n_vec++; if (bus_a.out_valid !== 1'b1 || bus_a.dout !== 16'sd144) begin n_err++; $display("FAIL t3_first: valid=%0b dout=%0d required 1/144", bus_a.out_valid, bus_a.dout); end
      @(posedge clk); #1;
      n_vec++; if (bus_a.out_valid !== 1'b1 || bus_a.dout !== -16'sd16) begin n_err++; $display("FAIL t3_second: valid=%0b dout=%0d required 1/-16", bus_a.out_valid, bus_a.dout); end
      @(posedge clk);
      wait_drain();
   endtask

   task automatic test_stall();
      set_ready(1'b0);
      send_beat(fill(4'd2), 16'hFFFF, 1'b1, 0);
      send_beat(fill(4'hE), 16'hFFFF, 1'b1, 0);
      #1 bus_a.in_valid = 1'b0;
      @(posedge clk);
      for (int i = 0; i < 5; i++) begin
         #1;
         n_vec++;
         if (bus_a.in_ready !== 1'b0 || bus_a.out_valid !== 1'b1 || bus_a.dout !== 16'sd32) begin
            n_err++;
            $display("FAIL t4_hold: ready=%0b valid=%0b dout=%0d required 0/1/32", bus_a.in_ready, bus_a.out_valid, bus_a.dout);
         end
         @(posedge clk);
      end
      set_ready(1'b1);
      wait_drain();
   endtask

   task automatic test_saturate();
      send_beat(fill(4'd7), 16'hFFFF, 1'b0, 0);
      send_beat(fill(4'd7), 16'hFFFF, 1'b1, 0);
      send_beat(fill(4'd1), 16'hFFFF, 1'b1, 0);
      idle(1);
      wait_drain();
   endtask

   task automatic test_mid_reset();
      send_beat(fill(4'd5), 16'hFFFF, 1'b0, 0);
      send_beat(fill(4'd5), 16'hFFFF, 1'b0, 0);
      #1;
      rst = 1'b1;
      bus_a.in_valid = 1'b0;
      bus_a.in_last  = 1'b0;
      #1;
      n_vec++; if (bus_a.out_valid !== 1'b0 || bus_a.dout !== 16'sd0) begin n_err++; $display("FAIL t6_rst_a: valid=%0b dout=%0d required 0/0", bus_a.out_valid, bus_a.dout); end
      n_vec++; if (bus_b.out_valid !== 1'b0 || bus_b.dout !== 8'sd0) begin n_err++; $display("FAIL t6_rst_b: valid=%0b dout=%0d required 0/0", bus_b.out_valid, bus_b.dout); end
      acc_a = 0; acc_b = 0; sat_a = 0; sat_b = 0;
      q_a.delete(); q_b.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      send_beat(fill(4'd1), 16'hFFFF, 1'b1, 0);
      idle(1);
      wait_drain();
   endtask

   task automatic test_random();
      rand_done = 1'b0;
      fork
         begin
            for (int g = 0; g < 12; g++) begin
               int len, th;
               len = $urandom_range(1, 4);
               th  = $urandom_range(0, 64) - 32;
               for (int b = 0; b < len; b++)
                  send_beat({$urandom(), $urandom()}, 16'($urandom()), (b == len - 1), th);
            end
            idle(1);
            rand_done = 1'b1;
         end
         begin
            for (int i = 0; i < 3000 && !rand_done; i++) begin
               @(posedge clk);
               #1 bus_a.out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      set_ready(1'b1);
      wait_drain();
   endtask

   initial begin
      test_reset();
      test_single();
      test_negate();
      test_back_to_back();
      test_stall();
      test_saturate();
      test_mid_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
